// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC_R,
      S_EXEC_I,
      S_ALUWB,
      S_BRANCH,
      S_JAL
   } state_t;

   // Opcodes
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // ALU operations
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ALU operation class requested by the FSM
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Operand / result selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_SW:   imm_sel = IMM_S;
         OP_BR:   imm_sel = IMM_B;
         OP_JAL:  imm_sel = IMM_J;
         default: imm_sel = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// ALU control decode and instruction legality check.
// Latency: combinational.
// Backpressure: none.
// Ports: op_i/funct3_i/funct7_5_i from IR, alu_op_i from FSM;
//        alu_ctrl_o to ALU, illegal_o flags any unsupported encoding.
module mc_alu_decode
   import cpu_pkg::*;
(
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_5_i,
   input  logic [1:0] alu_op_i,
   output logic [2:0] alu_ctrl_o,
   output logic       illegal_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_SUB: alu_ctrl_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // funct7[5] only means sub for register-register ops;
               // for addi it is just an immediate bit.
               3'b000:  alu_ctrl_o = (op_i == OP_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
               3'b111:  alu_ctrl_o = ALU_AND;
               3'b110:  alu_ctrl_o = ALU_OR;
               3'b010:  alu_ctrl_o = ALU_SLT;
               default: alu_ctrl_o = ALU_ADD;
            endcase
         end
         default: alu_ctrl_o = ALU_ADD;
      endcase
   end

   always_comb begin
      illegal_o = 1'b0;
      case (op_i)
         OP_LW, OP_SW, OP_JAL: illegal_o = 1'b0;
         OP_R, OP_I:
            illegal_o = !(funct3_i == 3'b000 || funct3_i == 3'b111 ||
                          funct3_i == 3'b110 || funct3_i == 3'b010);
         OP_BR:
            illegal_o = !(funct3_i == 3'b000 || funct3_i == 3'b001);
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM: sequences shared ALU/memory/regfile/PC/IR.
// Latency: branch 3, R/I/sw/jal 4, lw 5 cycles, plus one per mem wait cycle.
// Backpressure: holds in FETCH/MEMRD/MEMWR with mem_req high until mem_ready.
// Ports: instr/EQ/mem_ready in; datapath enables, mux selects, ALUctrl,
//        illegal pulse and instret counter out.
module mc_control
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        EQ,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegWrite,
   output logic [1:0]  ALUsrcA,
   output logic [1:0]  ALUsrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUctrl,
   output logic        illegal,
   output logic [31:0] instret
);

   state_t      state_q, state_d;
   logic [31:0] instret_q, instret_d;

   logic [6:0]  op;
   logic [2:0]  funct3;
   logic [1:0]  alu_op;
   logic [2:0]  dec_ctrl;
   logic        dec_illegal;
   logic        retire;

   assign op     = instr[6:0];
   assign funct3 = instr[14:12];

   wire unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   always_comb begin
      case (state_q)
         S_EXEC_R, S_EXEC_I: alu_op = ALUOP_FUNCT;
         S_BRANCH:           alu_op = ALUOP_SUB;
         default:            alu_op = ALUOP_ADD;
      endcase
   end

   mc_alu_decode u_alu_decode (
      .op_i       (op),
      .funct3_i   (funct3),
      .funct7_5_i (instr[30]),
      .alu_op_i   (alu_op),
      .alu_ctrl_o (dec_ctrl),
      .illegal_o  (dec_illegal)
   );

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (dec_illegal) state_d = S_FETCH;
            else begin
               case (op)
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_R:         state_d = S_EXEC_R;
                  OP_I:         state_d = S_EXEC_I;
                  OP_BR:        state_d = S_BRANCH;
                  OP_JAL:       state_d = S_JAL;
                  default:      state_d = S_FETCH;
               endcase
            end
         end
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_EXEC_R: state_d = S_ALUWB;
         S_EXEC_I: state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JAL:    state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // jal retires through ALUWB; illegal DECODE->FETCH does not retire.
   assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                   (state_q == S_BRANCH) || (state_q == S_MEMWR && mem_ready);
   assign instret_d = retire ? instret_q + 32'd1 : instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;

   // Moore decode; everything is gated by rst_n so an access in flight
   // is dropped the moment reset asserts, without waiting for mem_ready.
   always_comb begin
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      illegal   = 1'b0;
      ALUsrcA   = SRCA_PC;
      ALUsrcB   = SRCB_RS2;
      ResultSrc = RES_ALUOUT;
      ImmSrc    = IMM_I;
      ALUctrl   = ALU_ADD;
      if (rst_n) begin
         ImmSrc = imm_sel(op);
         case (state_q)
            S_FETCH: begin
               mem_req   = 1'b1;
               ALUsrcA   = SRCA_PC;
               ALUsrcB   = SRCB_FOUR;
               ResultSrc = RES_ALU;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
            end
            S_DECODE: begin
               ALUsrcA = SRCA_OLDPC;
               ALUsrcB = SRCB_IMM;
               illegal = dec_illegal;
            end
            S_MEMADR: begin
               ALUsrcA = SRCA_RS1;
               ALUsrcB = SRCB_IMM;
            end
            S_MEMRD: begin
               mem_req = 1'b1;
               AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
               ResultSrc = RES_DATA;
               RegWrite  = 1'b1;
            end
            S_MEMWR: begin
               mem_req  = 1'b1;
               MemWrite = 1'b1;
               AdrSrc   = 1'b1;
            end
            S_EXEC_R: begin
               ALUsrcA = SRCA_RS1;
               ALUsrcB = SRCB_RS2;
               ALUctrl = dec_ctrl;
            end
            S_EXEC_I: begin
               ALUsrcA = SRCA_RS1;
               ALUsrcB = SRCB_IMM;
               ALUctrl = dec_ctrl;
            end
            S_ALUWB: begin
               ResultSrc = RES_ALUOUT;
               RegWrite  = 1'b1;
            end
            S_BRANCH: begin
               ALUsrcA   = SRCA_RS1;
               ALUsrcB   = SRCB_RS2;
               ALUctrl   = dec_ctrl;
               ResultSrc = RES_ALUOUT;
               PCWrite   = (funct3 == 3'b000 && EQ) || (funct3 == 3'b001 && !EQ);
            end
            S_JAL: begin
               ALUsrcA   = SRCA_OLDPC;
               ALUsrcB   = SRCB_FOUR;
               ResultSrc = RES_ALUOUT;
               PCWrite   = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class cycle by cycle.
// Latency: n/a.
// Backpressure: mem_ready stalls driven from the stimulus.
module tb_mc_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        EQ;
   logic        mem_ready;
   logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
   logic [1:0]  ALUsrcA, ALUsrcB, ResultSrc, ImmSrc;
   logic [2:0]  ALUctrl;
   logic [31:0] instret;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_ret = 0;

   // enable vector: {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal}
   localparam logic [5:0] EN_NONE   = 6'b000000;
   localparam logic [5:0] EN_FETCH  = 6'b101100;
   localparam logic [5:0] EN_FWAIT  = 6'b100000;
   localparam logic [5:0] EN_MEMRD  = 6'b100000;
   localparam logic [5:0] EN_MEMWR  = 6'b110000;
   localparam logic [5:0] EN_REGWR  = 6'b000010;
   localparam logic [5:0] EN_PCWR   = 6'b000100;
   localparam logic [5:0] EN_ILL    = 6'b000001;

   always #5 clk = ~clk;

   mc_control dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .instr     (instr),
      .EQ        (EQ),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .MemWrite  (MemWrite),
      .AdrSrc    (AdrSrc),
      .IRWrite   (IRWrite),
      .PCWrite   (PCWrite),
      .RegWrite  (RegWrite),
      .ALUsrcA   (ALUsrcA),
      .ALUsrcB   (ALUsrcB),
      .ResultSrc (ResultSrc),
      .ImmSrc    (ImmSrc),
      .ALUctrl   (ALUctrl),
      .illegal   (illegal),
      .instret   (instret)
   );

   function automatic logic [5:0] en();
      return {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change just after the falling edge and
   // outputs are sampled 2 time units later, well away from the rising edge.
   task automatic cyc(input logic ready, input logic eq);
      @(negedge clk);
      mem_ready = ready;
      EQ        = eq;
      #2;
   endtask

   // Entry: observing FETCH. Exit: observing the next FETCH.
   task automatic run_alu(input string tag, input logic [31:0] ins,
                          input logic [2:0] ctrl, input logic is_imm);
      instr = ins;
      check({tag, "_fetch"}, 32'(en()), 32'(EN_FETCH));
      cyc(1'b1, 1'b0);
      check({tag, "_dec"}, 32'(en()), 32'(EN_NONE));
      cyc(1'b1, 1'b0);
      check({tag, "_exec_en"}, 32'(en()), 32'(EN_NONE));
      check({tag, "_ctrl"}, 32'(ALUctrl), 32'(ctrl));
      check({tag, "_srcs"}, 32'({ALUsrcA, ALUsrcB}), 32'({2'b10, is_imm ? 2'b01 : 2'b00}));
      cyc(1'b1, 1'b0);
      check({tag, "_wb"}, 32'({en(), ResultSrc}), 32'({EN_REGWR, 2'b00}));
      cyc(1'b1, 1'b0);
      exp_ret++;
      check({tag, "_instret"}, instret, exp_ret);
   endtask

   task automatic run_branch(input string tag, input logic [31:0] ins,
                             input logic eq, input logic taken);
      instr = ins;
      check({tag, "_fetch"}, 32'(en()), 32'(EN_FETCH));
      cyc(1'b1, 1'b0);
      check({tag, "_dec"}, 32'({en(), ImmSrc}), 32'({EN_NONE, 2'b10}));
      cyc(1'b1, eq);
      check({tag, "_br_en"}, 32'(en()), 32'(taken ? EN_PCWR : EN_NONE));
      check({tag, "_br_ctrl"}, 32'(ALUctrl), 32'(3'b001));
      cyc(1'b1, 1'b0);
      exp_ret++;
      check({tag, "_instret"}, instret, exp_ret);
   endtask

   task automatic run_illegal(input string tag, input logic [31:0] ins);
      instr = ins;
      cyc(1'b1, 1'b0);
      check({tag, "_dec"}, 32'(en()), 32'(EN_ILL));
      cyc(1'b1, 1'b0);
      check({tag, "_back"}, 32'(en()), 32'(EN_FETCH));
      check({tag, "_instret"}, instret, exp_ret);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      instr = 32'h0;
      EQ = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("rst_en", 32'(en()), 32'(EN_NONE));
      check("rst_sel", 32'({AdrSrc, ALUsrcA, ALUsrcB, ResultSrc, ImmSrc, ALUctrl}), 32'h0);
      check("rst_instret", instret, 32'h0);
      mem_ready = 1'b1;
      #1;
      check("rst_en_rdy", 32'(en()), 32'(EN_NONE));

      // Release: FETCH requests straight away.
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check("rel_fetch_sel", 32'({AdrSrc, ALUsrcA, ALUsrcB, ResultSrc}), 32'({1'b0, 2'b00, 2'b10, 2'b10}));

      run_alu("addi", 32'h00500093, 3'b000, 1'b1);

      // lw with three wait cycles in MEMRD: 8 cycles total.
      instr = 32'h0000A103;
      check("lw_fetch", 32'(en()), 32'(EN_FETCH));
      cyc(1'b1, 1'b0);
      check("lw_dec", 32'({en(), ImmSrc}), 32'({EN_NONE, 2'b00}));
      cyc(1'b1, 1'b0);
      check("lw_adr", 32'({en(), ALUsrcA, ALUsrcB, ALUctrl}), 32'({EN_NONE, 2'b10, 2'b01, 3'b000}));
      for (int i = 0; i < 4; i++) begin
         cyc(i == 3, 1'b0);
         check($sformatf("lw_rd%0d", i), 32'({en(), AdrSrc}), 32'({EN_MEMRD, 1'b1}));
      end
      cyc(1'b1, 1'b0);
      check("lw_wb", 32'({en(), ResultSrc}), 32'({EN_REGWR, 2'b01}));
      cyc(1'b1, 1'b0);
      exp_ret++;
      check("lw_instret", instret, exp_ret);

      run_branch("beq", 32'h00208463, 1'b1, 1'b1);
      run_branch("bne", 32'h00209463, 1'b1, 1'b0);
      run_alu("sub", 32'h40208033, 3'b001, 1'b0);
      run_alu("and", 32'h0020F033, 3'b010, 1'b0);
      run_alu("slt", 32'h0020A033, 3'b101, 1'b0);

      run_illegal("ill7f", 32'h0000007F);
      run_illegal("illbr", 32'h0020A463);
      run_illegal("illsll", 32'h00209033);

      // jal, with one FETCH wait cycle first.
      instr = 32'h008000EF;
      mem_ready = 1'b0;
      #1;
      check("jal_fwait", 32'(en()), 32'(EN_FWAIT));
      cyc(1'b1, 1'b0);
      check("jal_fetch", 32'(en()), 32'(EN_FETCH));
      cyc(1'b1, 1'b0);
      check("jal_dec", 32'({en(), ImmSrc}), 32'({EN_NONE, 2'b11}));
      cyc(1'b1, 1'b0);
      check("jal_j", 32'({en(), ALUsrcA, ALUsrcB, ResultSrc}), 32'({EN_PCWR, 2'b01, 2'b10, 2'b00}));
      cyc(1'b1, 1'b0);
      check("jal_wb", 32'(en()), 32'(EN_REGWR));
      cyc(1'b1, 1'b0);
      exp_ret++;
      check("jal_instret", instret, exp_ret);

      // sw stalled in MEMWR, then reset mid-access.
      instr = 32'h0020A023;
      cyc(1'b1, 1'b0);
      check("sw_dec", 32'({en(), ImmSrc}), 32'({EN_NONE, 2'b01}));
      cyc(1'b1, 1'b0);
      check("sw_adr", 32'({en(), ImmSrc}), 32'({EN_NONE, 2'b01}));
      cyc(1'b0, 1'b0);
      check("sw_wr0", 32'({en(), AdrSrc}), 32'({EN_MEMWR, 1'b1}));
      cyc(1'b0, 1'b0);
      check("sw_wr1", 32'({en(), AdrSrc}), 32'({EN_MEMWR, 1'b1}));
      rst_n = 1'b0;
      #1;
      check("sw_rst_en", 32'(en()), 32'(EN_NONE));
      check("sw_rst_instret", instret, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      #2;
      check("post_rst_fetch", 32'(en()), 32'(EN_FETCH));
      check("post_rst_instret", instret, 32'h0);
      cyc(1'b1, 1'b0);
      check("post_rst_dec", 32'(en()), 32'(EN_NONE));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the RV32I core. It sequences the shared datapath (single ALU, single unified instruction/data memory port, register file, PC, IR) through fetch, decode, execute, memory and writeback states. It stalls on a memory ready handshake and counts retired instructions. It sits between the IR/ALU-flag outputs and every datapath enable and mux select.

## Interface

No parameters.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- instr  in  32  IR contents; must be stable from DECODE until return to FETCH
- EQ  in  1  ALU zero flag, combinational from the current ALU operation
- mem_ready  in  1  memory has completed the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  write qualifier for mem_req
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- IRWrite  out  1  latch memory read data into IR
- PCWrite  out  1  load PC from the Result bus
- RegWrite  out  1  write Result to rd
- ALUsrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- ALUsrcB  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data register, 10 = ALU result
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
- instret  out  32  retired-instruction count

## Operation

- Supported instructions: lw (0000011), sw (0100011), R-type (0110011: add, sub, and, or, slt), I-ALU (0010011: addi, andi, ori, slti), branch (1100011: beq funct3 000, bne funct3 001), jal (1101111).
- Any other opcode, or a branch with another funct3, is illegal.
- States and the outputs asserted in each; unlisted enables are 0 and unlisted selects are don't-care:
  - FETCH: mem_req=1, AdrSrc=0, ALUsrcA=00, ALUsrcB=10, ALUctrl=add, ResultSrc=10. IRWrite and PCWrite are asserted only in the cycle mem_ready=1. Go to DECODE on mem_ready, otherwise hold.
  - DECODE: ALUsrcA=01, ALUsrcB=01, ALUctrl=add (branch/jal target into ALUOut). ImmSrc is taken from the opcode. Next state: lw/sw → MEMADR; R → EXEC_R; I → EXEC_I; branch → BRANCH; jal → JAL; illegal → FETCH with the illegal pulse.
  - MEMADR: ALUsrcA=10, ALUsrcB=01, ALUctrl=add. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req=1, AdrSrc=1. Go to MEMWB on mem_ready, otherwise hold.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWR: mem_req=1, MemWrite=1, AdrSrc=1. Go to FETCH on mem_ready, otherwise hold.
  - EXEC_R: ALUsrcA=10, ALUsrcB=00, ALUctrl decoded. Go to ALUWB.
  - EXEC_I: ALUsrcA=10, ALUsrcB=01, ALUctrl decoded. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BRANCH: ALUsrcA=10, ALUsrcB=00, ALUctrl=sub, ResultSrc=00. PCWrite = (beq & EQ) | (bne & ~EQ). Go to FETCH.
  - JAL: ALUsrcA=01, ALUsrcB=10, ALUctrl=add, ResultSrc=00, PCWrite=1. Go to ALUWB, which writes PC+4 to rd.
- ALU decode rules:
  - funct3 000 gives sub only for R-type with funct7[5]=1; otherwise add.
  - funct3 111 → and; 110 → or; 010 → slt.
  - Any other funct3 under R/I-type is illegal.
- Retirement:
  - instret increments by 1 on the cycle the state returns to FETCH from MEMWB, MEMWR (with mem_ready), ALUWB or BRANCH.
  - Illegal instructions do not retire.
  - instret wraps modulo 2^32.
- Outputs are Moore-decoded from state. The exceptions are PCWrite/IRWrite in FETCH (gated by mem_ready) and PCWrite in BRANCH (uses EQ); these are combinational from inputs.

## Timing

- Reset:
  - While rst_n=0: state=FETCH, instret=0, and all enables (mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal) are forced 0 asynchronously.
  - Selects go to 0.
  - FETCH requests in the first cycle after deassertion.
- Latency with mem_ready tied to 1: branch 3 cycles; R, I and sw 4 cycles; jal 4 cycles; lw 5 cycles. Each wait cycle on mem_ready adds one cycle.
- Handshake: mem_req stays high and the address select stays stable until mem_ready. mem_ready while mem_req=0 is ignored.
- Reset asserted mid-access (e.g. in MEMWR): MemWrite and mem_req drop in the same cycle, with no waiting for mem_ready.

## Structure

- Package cpu_pkg holds:
  - the state_t enum;
  - opcode constants;
  - ALUctrl constants;
  - the ALUsrcA/B, ResultSrc and ImmSrc encodings.
- One sub-module, mc_alu_decode, is combinational: (op, funct3, funct7[5], ALUOp) → ALUctrl and an illegal flag.

## Test plan

- addi x1,x0,5 (0x00500093), mem_ready=1 → states FETCH, DECODE, EXEC_I, ALUWB; RegWrite high only in cycle 4; ALUctrl=000; instret=1.
- lw (0x0000A103) with mem_ready held low for 3 cycles in MEMRD → mem_req and AdrSrc=1 held for 4 cycles; RegWrite with ResultSrc=01 exactly once; total 8 cycles.
- beq with EQ=1 → PCWrite=1 in BRANCH; bne (funct3 001) with EQ=1 → PCWrite=0; both retire in 3 cycles.
- sub (0x40208033) → ALUctrl=001 in EXEC_R; and (funct3 111) → 010; slt (funct3 010) → 101.
- Opcode 0x7F → illegal pulse in DECODE, next state FETCH, instret unchanged, no RegWrite or MemWrite.
- sw stalled in MEMWR, rst_n pulled low → MemWrite and mem_req go 0 immediately; after release, state is FETCH and instret=0.
